math_multiplier_arbiter: RTL

- Shares one combinational N×N array multiplier, `math_multiplier_array`, between two requesters.
- Round-robin arbitration on a valid/ready request interface.
- One registered operand stage feeds the array; each requester gets its own one-deep registered result buffer.
- Sits between two datapath clients and the single array instance, which is instantiated inside this block.

---
 rtl/math_multiplier_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/math_multiplier_arbiter.sv
// Round-robin arbiter that shares one combinational N x N array multiplier
// between two valid/ready requesters, with one result buffer per requester.

module math_multiplier_array #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] acc [N+1];

    assign acc[0] = '0;

    // Each row adds the multiplicand shifted by its bit position when that multiplier bit is set.
    for (genvar i = 0; i < N; i++) begin : g_row
        assign acc[i+1] = acc[i] + (b[i] ? ({{N{1'b0}}, a} << i) : '0);
    end

    assign p = acc[N];

endmodule

module math_multiplier_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*N-1:0] rsp0_p,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*N-1:0] rsp1_p,
    output logic           busy
);

    logic           stage_valid;
    logic           stage_tag;
    logic [N-1:0]   stage_a;
    logic [N-1:0]   stage_b;
    logic           last;
    logic [2*N-1:0] product;
    logic           elig0;
    logic           elig1;
    logic           gnt0;
    logic           gnt1;

    math_multiplier_array #(.N(N)) u_array (
        .a (stage_a),
        .b (stage_b),
        .p (product)
    );

    // A requester qualifies only when neither its buffer nor the operand stage holds its work,
    // so a buffer is never written while full.
    always_comb begin
        // NOTE: every signal is assigned on every pass, so no latch can be inferred.
        elig0 = req0_valid && !rsp0_valid && !(stage_valid && !stage_tag);
        elig1 = req1_valid && !rsp1_valid && !(stage_valid && stage_tag);
        gnt0  = elig0 && (!elig1 || last);
        gnt1  = elig1 && (!elig0 || !last);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = stage_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_tag   <= 1'b0;
            stage_a     <= '0;
            stage_b     <= '0;
            last        <= 1'b1;
            rsp0_valid  <= 1'b0;
            rsp0_p      <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_p      <= '0;
        end else begin
            // NOTE: non-blocking updates let the retiring op read the old stage while the new one is captured.
            stage_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                stage_a   <= gnt0 ? req0_a : req1_a;
                stage_b   <= gnt0 ? req0_b : req1_b;
                stage_tag <= gnt1;
                last      <= gnt1;
            end

            if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
            if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;

            if (stage_valid) begin
                if (stage_tag) begin
                    rsp1_valid <= 1'b1;
                    rsp1_p     <= product;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_p     <= product;
                end
            end
        end
    end

endmodule
